// File: rtl/tick_dispatch.sv
// tick_dispatch: queues one-cycle ticks from the upstream tick generator in a
// saturating pending counter and issues each as one req/ack handshake to a
// slave. A watchdog aborts a request that has gone unacknowledged for TOUT
// cycles. Overflow and completion counters are kept for observability.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   tick      in   one-cycle tick pulse from upstream
//   ack       in   slave acknowledge, only meaningful while req=1
//   req       out  request to slave (state REQ)
//   pend      out  [PBITS-1:0] queued ticks not yet issued
//   busy      out  state is not IDLE
//   tout      out  one-cycle pulse after a watchdog abort
//   ovf       out  sticky, a tick was dropped at saturation
//   done_cnt  out  [DBITS-1:0] completed handshakes, wraps
module tick_dispatch #(
  parameter int PBITS = 4,
  parameter int MAXP  = 10,
  parameter int TOUT  = 16,
  parameter int TBITS = 5,
  parameter int DBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             ack,
  output logic             req,
  output logic [PBITS-1:0] pend,
  output logic             busy,
  output logic             tout,
  output logic             ovf,
  output logic [DBITS-1:0] done_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  localparam logic [TBITS-1:0] TLAST = TBITS'(TOUT - 1);
  localparam logic [PBITS-1:0] PMAX  = PBITS'(MAXP);

  state_t           state, state_nx;
  logic [TBITS-1:0] timer, timer_nx;
  logic             issue, acked, expire;

  // issue doubles as the pending-counter decrement
  assign issue  = (state == IDLE) && (pend != '0);
  assign acked  = (state == REQ) && ack;
  // ack takes precedence over a coincident watchdog expiry
  assign expire = (state == REQ) && !ack && (timer == TLAST);

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    case (state)
      IDLE: begin
        if (issue) begin
          state_nx = REQ;
          timer_nx = '0;
        end
      end
      REQ: begin
        if (acked || expire) state_nx = GAP;
        else                 timer_nx = timer + TBITS'(1);
      end
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      pend     <= '0;
      tout     <= 1'b0;
      ovf      <= 1'b0;
      done_cnt <= '0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      tout  <= expire;
      if (acked) done_cnt <= done_cnt + DBITS'(1);
      // simultaneous inc/dec cancel; an inc at saturation is lost
      case ({tick, issue})
        2'b10: begin
          if (pend == PMAX) ovf  <= 1'b1;
          else              pend <= pend + PBITS'(1);
        end
        2'b01:   pend <= pend - PBITS'(1);
        default: pend <= pend;
      endcase
    end
  end

  assign req  = (state == REQ);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_tick_dispatch.sv
module tb_tick_dispatch;
  localparam int PBITS = 4, MAXP = 10, TOUT = 16, TBITS = 5, DBITS = 8;

  logic clk = 1'b0, rst, tick, ack;
  logic req, busy, tout, ovf;
  logic [PBITS-1:0] pend;
  logic [DBITS-1:0] done_cnt;

  tick_dispatch #(.PBITS(PBITS), .MAXP(MAXP), .TOUT(TOUT), .TBITS(TBITS), .DBITS(DBITS)) dut (
    .clk(clk), .rst(rst), .tick(tick), .ack(ack), .req(req), .pend(pend),
    .busy(busy), .tout(tout), .ovf(ovf), .done_cnt(done_cnt));

  always #5 clk = ~clk;

  int vectors = 0, errors = 0;

  // reference: queue depth, an in-flight request with its age, a cool-down slot
  int m_pend, m_done, m_age;
  bit m_act, m_cool, m_ovf, m_tout;
  int ack_dly;  // -1 never ack, -2 random ack, else ack at that request age

  // observation stats
  int req_starts, tout_cnt, run, max_run;
  bit prev_req;

  task automatic chk(string tag, logic [31:0] obs, int exp);
    vectors++;
    if (obs !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    req_starts = 0; tout_cnt = 0; run = 0; max_run = 0;
  endtask

  task automatic model_step(bit t, bit a, bit r);
    bit iss;
    int np;
    if (r) begin
      m_pend = 0; m_done = 0; m_age = 0; m_act = 0; m_cool = 0; m_ovf = 0; m_tout = 0;
      return;
    end
    iss = !m_act && !m_cool && (m_pend > 0);
    np = m_pend + int'(t) - int'(iss);
    if (np > MAXP) begin np = MAXP; m_ovf = 1; end
    m_tout = 0;
    if (m_act) begin
      if (a) begin m_done = (m_done + 1) % (1 << DBITS); m_act = 0; m_cool = 1; end
      else if (m_age == TOUT - 1) begin m_tout = 1; m_act = 0; m_cool = 1; end
      else m_age++;
    end else if (m_cool) m_cool = 0;
    else if (iss) begin m_act = 1; m_age = 0; end
    m_pend = np;
  endtask

  // one clock: check state left by previous edge, drive inputs, advance model
  task automatic cyc(bit t, bit r);
    bit a;
    @(negedge clk);
    chk("req", 32'(req), int'(m_act));
    chk("pend", 32'(pend), m_pend);
    chk("busy", 32'(busy), int'(m_act || m_cool));
    chk("tout", 32'(tout), int'(m_tout));
    chk("ovf", 32'(ovf), int'(m_ovf));
    chk("done_cnt", 32'(done_cnt), m_done);
    if (req === 1'b1 && !prev_req) req_starts++;
    if (req === 1'b1) begin run++; if (run > max_run) max_run = run; end else run = 0;
    if (tout === 1'b1) tout_cnt++;
    prev_req = (req === 1'b1);
    if (ack_dly == -2) a = bit'($urandom_range(1, 0));
    else a = (ack_dly >= 0) && m_act && (m_age == ack_dly);
    tick = t; ack = a; rst = r;
    @(posedge clk);
    model_step(t, a, r);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0);
  endtask

  int d0, nt;

  initial begin
    rst = 1; tick = 0; ack = 0; ack_dly = -1; prev_req = 0;
    repeat (2) @(posedge clk);
    model_step(0, 0, 1);
    clr_stats();

    // single tick at cycle 5, ack on 3rd req cycle
    ack_dly = 2;
    cyc(0, 1);
    idle(4); cyc(1, 0); idle(15);
    chk("t1_req_starts", 32'(req_starts), 1);
    chk("t1_req_len", 32'(max_run), 3);
    chk("t1_done", 32'(done_cnt), 1);
    chk("t1_tout", 32'(tout_cnt), 0);

    // no ack: watchdog after TOUT cycles
    clr_stats(); ack_dly = -1; d0 = m_done;
    cyc(1, 0); idle(25);
    chk("t2_req_len", 32'(max_run), TOUT);
    chk("t2_tout_pulses", 32'(tout_cnt), 1);
    chk("t2_done", 32'(done_cnt), d0);
    chk("t2_busy", 32'(busy), 0);

    // 12-tick burst, no ack: saturation and overflow
    clr_stats();
    for (int i = 0; i < 12; i++) cyc(1, 0);
    idle(11 * (TOUT + 3) + 10);
    chk("t3_req_starts", 32'(req_starts), 11);
    chk("t3_tout_pulses", 32'(tout_cnt), 11);
    chk("t3_ovf", 32'(ovf), 1);
    chk("t3_pend", 32'(pend), 0);

    // tick coinciding with issue, immediate ack, no loss
    cyc(0, 1);
    clr_stats(); ack_dly = 0; nt = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(i % 3 == 0, 0);
      if (i % 3 == 0) nt++;
    end
    idle(100);
    chk("t4_done", 32'(done_cnt), nt);
    chk("t4_ovf", 32'(ovf), 0);

    // ack on the last watchdog cycle
    clr_stats(); ack_dly = TOUT - 1; d0 = m_done;
    cyc(1, 0); idle(TOUT + 6);
    chk("t5_tout", 32'(tout_cnt), 0);
    chk("t5_done", 32'(done_cnt), (d0 + 1) % 256);

    // reset mid-handshake with queue depth 4
    ack_dly = -1;
    for (int i = 0; i < 5; i++) cyc(1, 0);
    cyc(0, 0);
    chk("t5_pre_req", 32'(req), 1);
    chk("t5_pre_pend", 32'(pend), 4);
    cyc(0, 1);
    cyc(0, 0);
    chk("t5_rst_req", 32'(req), 0);
    chk("t5_rst_pend", 32'(pend), 0);
    chk("t5_rst_done", 32'(done_cnt), 0);

    // 300 handshakes: done_cnt wraps to 44
    cyc(0, 1);
    clr_stats(); ack_dly = 1;
    for (int i = 0; i < 300; i++) begin cyc(1, 0); idle(3); end
    idle(20);
    chk("t6_done", 32'(done_cnt), 44);
    chk("t6_tout", 32'(tout_cnt), 0);
    chk("t6_ovf", 32'(ovf), 0);

    // random traffic with random ack and rare resets
    ack_dly = -2;
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(9, 0) < 3, $urandom_range(299, 0) == 0);
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
